// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART byte receiver: captures one byte per rx_status
// pulse and serves it to the CPU through a data/status register pair.
module uart_rx_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          THRESH    = 1,
  parameter logic [31:0] DATA_ADDR = 32'h4000_0024,
  parameter logic [31:0] STAT_ADDR = 32'h4000_0028
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_status,
  input  logic [31:0]     Add,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [ADDR_W:0] rx_count
);

  localparam logic [ADDR_W:0]   DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   THRESH_C = THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [7:0]        mem_q [DEPTH];
  logic              sync1_q, sync2_q, sync3_q;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        push_s, pop_s, accept_s, ovf_s, flush_s;
  logic        data_rd_s, stat_rd_s, stat_wr_s, full_s, empty_s;
  logic [31:0] cnt_wide_s;
  logic        unused_s;

  assign cnt_wide_s = {{(31-ADDR_W){1'b0}}, count_q};
  assign unused_s   = ^{wdata[31:3], cnt_wide_s[31:8]};

  always_comb begin
    push_s    = sync2_q & ~sync3_q;
    data_rd_s = rd && (Add == DATA_ADDR);
    stat_rd_s = rd && (Add == STAT_ADDR);
    stat_wr_s = wr && (Add == STAT_ADDR);
    full_s    = (count_q == DEPTH_C);
    empty_s   = (count_q == {(ADDR_W+1){1'b0}});
    pop_s     = data_rd_s && !empty_s;
    flush_s   = stat_wr_s && wdata[1];
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    accept_s  = push_s && (!full_s || pop_s) && !flush_s;
    ovf_s     = push_s && full_s && !pop_s && !flush_s;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_s) begin
      wptr_d  = {ADDR_W{1'b0}};
      rptr_d  = {ADDR_W{1'b0}};
      count_d = {(ADDR_W+1){1'b0}};
    end else begin
      if (accept_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({accept_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // A fresh overrun beats a clear requested on the same edge.
    if (ovf_s) begin
      overrun_d = 1'b1;
    end else if (stat_wr_s && wdata[2]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (stat_wr_s) begin
      irq_en_d = wdata[0];
    end else begin
      irq_en_d = irq_en_q;
    end
    irq_d = irq_en_d & ((count_d >= THRESH_C) | overrun_d);

    if (data_rd_s) begin
      if (empty_s) begin
        rdata_d = 32'h0000_0000;
      end else begin
        rdata_d = {24'h00_0000, mem_q[rptr_q]};
      end
    end else if (stat_rd_s) begin
      rdata_d = {16'h0000, cnt_wide_s[7:0], 4'h0, irq_en_q, overrun_q, full_s, !empty_s};
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Byte storage needs no reset; unread slots are never observed.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      wptr_q    <= {ADDR_W{1'b0}};
      rptr_q    <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
    end else begin
      sync1_q   <= rx_status;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign rx_count = count_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART byte receiver.
- Captures each received byte on the receiver's rx_status pulse and queues it in a FIFO.
- The CPU pops bytes through memory-mapped reads on the peripheral bus, so bytes arriving back-to-back are not lost between polls.
- Drives a level interrupt to the CPU interrupt logic.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH)
THRESH, 1, irq asserts when count >= THRESH; 1..DEPTH
DATA_ADDR, 32'h40000024, read address that pops one byte
STAT_ADDR, 32'h40000028, status register on read, control register on write

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
rx_data  in  8  receiver byte; stable while rx_status is high
rx_status  in  1  receiver byte-valid level, high for about 16 sig16 ticks, asynchronous to clk
Add  in  32  bus address
rd  in  1  bus read strobe, sampled at posedge clk
wr  in  1  bus write strobe, sampled at posedge clk
wdata  in  32  bus write data
rdata  out  32  registered read data
irq  out  1  level interrupt request
rx_count  out  ADDR_W+1  current occupancy, for debug LEDs

Behaviour:
- Reset (reset==0, asynchronous) clears the following: FIFO pointers, count, overrun, irq_en, rdata=0, irq=0, and the synchronizer/edge registers.
- FIFO RAM contents are don't-care after reset.
- Capture path:
  - rx_status passes through a 2-FF synchronizer, then a rising-edge detect.
  - The edge produces a one-cycle push of rx_data into the FIFO.
  - A push happens on the 3rd posedge clk after rx_status rises.
  - Exactly one push per rx_status high period, regardless of its length.
- Push when full (count==DEPTH): byte dropped, overrun set (sticky), pointers unchanged.
- Read DATA_ADDR (rd==1 && Add==DATA_ADDR):
  - Non-empty: rdata <= {24'b0, head} on that edge; read pointer increments; count decrements.
  - Empty: rdata <= 0; no pointer change; no underflow.
- Read STAT_ADDR: rdata <= {16'b0, count zero-extended to 8 bits, 4'b0, irq_en, overrun, full, not_empty}.
  - full = bit1, not_empty = bit0, overrun = bit2, irq_en = bit3, count in [15:8].
  - Reading does not clear overrun.
- rd==1 with any other Add, or rd==0: rdata <= 0.
- Write STAT_ADDR (wr==1 && Add==STAT_ADDR):
  - wdata[0] -> irq_en.
  - wdata[1]==1: flush; both pointers and count go to 0 on that edge.
  - wdata[2]==1: clear overrun.
  - Writes to any other address are ignored.
- Simultaneous events on the same edge:
  - push + pop, not full and not empty: both happen, count unchanged.
  - push + pop while full: pop first, push accepted, overrun not set.
  - push + pop while empty: push accepted, pop returns 0, count becomes 1.
  - push + flush: flush wins, pushed byte discarded, count=0.
  - push + overrun-clear while full: the new overrun wins, so overrun stays 1.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits, 0..DEPTH.
- irq is registered: irq <= irq_en & ((count_next >= THRESH) | overrun_next). It updates on the same edge as the state change.
- rx_count mirrors count.
- Reset while a byte is mid-reception: the byte is lost if rx_status is still low at reset release. If rx_status is already high at release, that byte is pushed 3 cycles after release.

Test Plan:
- Reset, then one rx_status pulse with rx_data=8'h5A -> push on 3rd clk. Read STAT_ADDR gives 32'h0000_0101. Read DATA_ADDR gives 32'h0000_005A. Next STAT read gives 32'h0000_0000.
- 17 pulses with bytes 8'h00..8'h10, DEPTH=16 -> STAT reads 32'h0000_1006 (full, overrun). 16 DATA reads return 8'h00..8'h0F in order; the 17th returns 0. Write wdata=4 -> overrun cleared.
- Write STAT wdata=1 (irq_en) with THRESH=1 -> irq=0 while empty. After one push, irq=1 on the push edge. After the pop, irq=0 on the pop edge.
- FIFO full, DATA read on the same edge as a push of 8'hAA -> count stays 16, overrun=0. The last DATA read of the drain returns 8'hAA.
- 5 bytes queued, then write wdata=2 coincident with a push -> count=0, STAT reads 32'h0000_0000, DATA read returns 0.
- 3 bytes queued, reset pulsed low between clock edges -> rdata=0, irq=0, and STAT reads 0 immediately after release.
